// File: rtl/mojo_pkg.sv
// mojo_pkg: board-wide constants shared by the Mojo HACK gate-test blocks.
package mojo_pkg;
  localparam int SW_WIDTH = 8;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEBOUNCE_CYCLES = CLK_HZ / 100;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch pins in, debounced levels and strobes out.
interface switch_debouncer_if import mojo_pkg::*; #(parameter int WIDTH = SW_WIDTH);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic changed;
  logic busy;
  modport master (output sw_raw, input sw_clean, sw_rise, sw_fall, changed, busy);
  modport slave (input sw_raw, output sw_clean, sw_rise, sw_fall, changed, busy);
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser, stability counter and edge strobes for one switch.
module debounce_bit import mojo_pkg::*; #(
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_evt_nxt,
  output logic o_busy_nxt
);
  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic r_s1, r_s2, r_clean, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic w_diff, w_take, w_clean_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  assign w_diff = r_s2 ^ r_clean;
  assign w_take = w_diff && (r_cnt == LAST);
  assign w_cnt_nxt = (w_diff && !w_take) ? r_cnt + 1'b1 : '0;
  assign w_clean_nxt = w_take ? r_s2 : r_clean;
  // busy is the registered image of (cnt != 0 || s2 != clean), so derive it from next-state values
  assign o_busy_nxt = (w_cnt_nxt != '0) || (r_s1 != w_clean_nxt);
  assign o_evt_nxt = w_take;
  assign o_clean = r_clean;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_cnt <= '0;
      r_clean <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_cnt <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise <= w_take & r_s2;
      r_fall <= w_take & ~r_s2;
    end
  end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit debouncing of the DIP-switch banks with aggregate changed/busy flags.
module switch_debouncer import mojo_pkg::*; #(
  parameter int WIDTH = SW_WIDTH,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input logic clk,
  input logic rst_n,
  switch_debouncer_if.slave sw
);
  logic [WIDTH-1:0] w_clean, w_rise, w_fall, w_evt, w_busy;
  logic r_changed, r_busy;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
      .clk(clk),
      .rst_n(rst_n),
      .i_raw(sw.sw_raw[i]),
      .o_clean(w_clean[i]),
      .o_rise(w_rise[i]),
      .o_fall(w_fall[i]),
      .o_evt_nxt(w_evt[i]),
      .o_busy_nxt(w_busy[i])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_changed <= |w_evt;
      r_busy <= |w_busy;
    end
  end
  assign sw.sw_clean = w_clean;
  assign sw.sw_rise = w_rise;
  assign sw.sw_fall = w_fall;
  assign sw.changed = r_changed;
  assign sw.busy = r_busy;
endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Debounces and synchronises the Mojo board's DIP-switch banks before they reach the HACK gate-test top level. The eight asynchronous switch pins (4-bit gate selector, 4-bit operand bank) enter a two-flop synchroniser and a per-bit stability counter. The block then presents clean levels plus single-cycle rise/fall strobes. The gate-test top consumes `sw_clean` in place of raw pins, so LED results never flicker on contact bounce.

## Interface
- `WIDTH`, default 8: number of switch bits; bit mapping is `{selector[3:0], operand[3:0]}`.
- `STABLE_CYCLES`, default 500000: cycles a new level must persist before acceptance (10 ms at 50 MHz); legal range ≥1.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`, minimum 1: counter width; derived, never overridden.
- `clk`  in  1: 50 MHz board clock.
- `rst_n`  in  1: one clock; reset is synchronous and active-low.
- `sw_raw`  in  WIDTH: asynchronous switch pins.
- `sw_clean`  out  WIDTH: debounced level.
- `sw_rise`  out  WIDTH: one-cycle pulse when a `sw_clean` bit goes 0→1.
- `sw_fall`  out  WIDTH: one-cycle pulse when a `sw_clean` bit goes 1→0.
- `changed`  out  1: OR of all `sw_rise | sw_fall`, in the same cycle.
- `busy`  out  1: high while any bit's counter is nonzero or its synchronised level differs from `sw_clean`.

## Operation
- Per bit, `s1 <= sw_raw`, then `s2 <= s1` (two-flop synchroniser).
- Mismatch rule, applied while `s2 != clean`:
  - If `cnt == STABLE_CYCLES-1`: `clean <= s2`, `cnt <= 0`, and pulse `rise` or `fall` according to the new value.
  - Otherwise: `cnt <= cnt + 1`.
- Match rule: while `s2 == clean`, `cnt <= 0`. Any bounce back to the old level restarts the count from zero.
- `cnt` never exceeds `STABLE_CYCLES-1`; no wrap-around is possible.
- Bits are fully independent. Several bits may update, and pulse, in the same cycle.
- Reset (`rst_n` low at a `clk` edge):
  - `s1`, `s2`, `cnt` and `clean` clear to 0.
  - `sw_rise`, `sw_fall`, `changed` and `busy` read 0 during reset and on the first cycle after it.
  - Reset mid-count aborts the count; no pulse is issued.
- After reset, any switch already high debounces normally. It produces one `sw_rise` pulse `STABLE_CYCLES+2` cycles after release. This is intended: downstream sees a defined power-up transition.
- `rst_n` asserted in the same cycle as an acceptance: reset wins, and no pulse is issued.

## Timing
- All outputs are registered; there is no combinational path from `sw_raw`.
- Latency: with `sw_raw` held at a new level, `sw_clean` changes on edge `STABLE_CYCLES+2`, counting the edge that first samples the new level into `s1` as edge 1.
- `sw_rise`/`sw_fall`/`changed` assert in exactly the same cycle that `sw_clean` takes its new value, for one cycle only.
- A disturbance shorter than `STABLE_CYCLES` cycles at `s2` is fully rejected: no output changes.
- `busy` is registered alongside `cnt`. It falls in the same cycle that `sw_clean` updates, or when a glitch resolves back to the old level.

## Structure
- Shared package `mojo_pkg` holds:
  - `SW_WIDTH = 8`
  - `CLK_HZ = 50_000_000`
  - `DEBOUNCE_CYCLES = CLK_HZ/100`
- Sub-module `debounce_bit` contains the synchroniser, counter and edge pulses for one bit.
  - `switch_debouncer` generates `WIDTH` instances.
  - It forms `changed` and `busy` as registered OR-reductions of per-bit signals computed before the register stage, so timing is preserved.

## Test plan
Bench parameters: `WIDTH=8`, `STABLE_CYCLES=4`. All scenarios start from 10 reset cycles with `sw_raw=0`.
- **Clean step.** Stimulus: `sw_raw` 0x00→0x05 and hold. Response: `sw_clean`=0x05 on edge 6; `sw_rise`=0x05 and `changed`=1 for exactly that cycle; `sw_fall`=0.
- **Glitch rejection.** Stimulus: bit 3 high for 3 cycles, then low. Response: `sw_clean` stays 0x00; no pulses; `busy` rises then returns to 0.
- **Bounce.** Stimulus: bit 0 toggles 1,0,1,0,1 at 2-cycle spacing, then holds 1. Response: exactly one `sw_rise[0]`, 6 edges after the final 0→1; never any `sw_fall[0]`.
- **Simultaneous multi-bit.** Stimulus: from `sw_clean`=0xF0, `sw_raw`→0x0F. Response: one cycle with `sw_rise`=0x0F, `sw_fall`=0xF0, `changed`=1; `sw_clean`=0x0F.
- **Reset mid-count.** Stimulus: `sw_raw`=0xFF; assert `rst_n`=0 on count cycle 2 for 1 cycle. Response: all outputs 0 during reset; no pulse before reset; after release, `sw_rise`=0xFF arrives 6 edges after release.
- **Power-up high.** Stimulus: hold `sw_raw`=0x81 through and after reset. Response: a single `sw_rise`=0x81, 6 edges after `rst_n` rises.
